instr_buffer: RTL and testbench
===============================

# instr_buffer

Circular instruction buffer between the fetch/decode stage and the issue/reservation-station stage. It accepts up to four decoded instructions per cycle in program order, holds them in a DEPTH-entry queue, and presents the oldest two to issue. It reports its free capacity back to fetch as the per-cycle fetch budget, and it empties completely on a taken jump.

## Interface
Parameters:
- DEPTH, 8: number of entries; must be a power of two and at least 4.
- DEQ_W, 2: number of dequeue lanes presented to issue.

Ports (arrays are unpacked `[0:3]` for enqueue and `[0:DEQ_W-1]` for dequeue):
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  taken jump; discard all contents.
- enq_count  in  3  number of valid enqueue lanes this cycle (0..4). Valid lanes are always lanes 0..enq_count-1.
- enq_opcode, enq_rt, enq_ra, enq_rb  in  4 each  decoded fields per lane.
- enq_a_dep, enq_b_dep  in  1 each  operand local-dependency flags.
- enq_a_owner, enq_b_owner  in  4 each  ROB owner index.
- enq_uses_rb, enq_is_ld_str, enq_is_fxu, enq_is_branch  in  1 each  class flags.
- free_slots  out  3  min(4, DEPTH - count); this is fetch's num_fetch.
- deq_valid  out  DEQ_W  lane i is valid iff i < count.
- deq_* (same 12 fields as enq_*)  out  per lane  contents of entry head+i.
- deq_count  in  2  number of lanes issue takes this cycle. It is a prefix count.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH x 30-bit entries holding the 12 fields. Pointers: head, tail, each log2(DEPTH) bits, wrapping mod DEPTH.
- Accepted enqueue: enq_acc = min(enq_count, free_slots). free_slots is computed from the pre-edge count. Lanes at or beyond enq_acc are dropped.
- Lane i is written to entry (tail+i) mod DEPTH. The update is tail += enq_acc.
- Accepted dequeue: deq_acc = min(deq_count, count, DEQ_W). The update is head += deq_acc.
- Count: count' = count + enq_acc - deq_acc. Because free_slots uses the pre-edge count, count never exceeds DEPTH. Space freed by a same-cycle dequeue is not reusable until the next cycle.
- Dequeue outputs are combinational reads of entries head..head+DEQ_W-1. Fields on invalid lanes are don't-care. The bench checks only valid lanes.
- Flush takes priority over everything:
  - On the flush edge, head, tail and count are set to 0.
  - Same-cycle enqueue and dequeue are ignored.
  - Entry storage is not cleared.
- Order: entries leave in exactly the order they arrived. Lane 0 of a group is older than lane 1 of the same group.

## Timing
- Reset (asynchronous, effective immediately):
  - head = tail = count = 0.
  - free_slots = 4.
  - deq_valid = 0.
  - err_overflow = 0 (when present).
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N appears on deq_* after edge N, if it is within head..head+DEQ_W-1. There is no same-cycle bypass.
- Edge cases:
  - Full (count = DEPTH): free_slots = 0 and all enqueue lanes are dropped.
  - Empty: deq_valid = 0 and deq_count is ignored.
  - Wrap-around: a 4-lane group that straddles entry DEPTH-1 continues at entry 0 with no bubble.
  - Reset asserted mid-operation aborts any in-flight update. The first edge after deassertion behaves as from empty.

## Configuration
- IBUF_OVERFLOW_CHK_EN defined:
  - Adds output err_overflow (out, 1 bit).
  - err_overflow is sticky. It is set on any edge where enq_count > free_slots and flush = 0.
  - It clears only on rst.
- Not defined: the port does not exist, and excess lanes are dropped silently.

## Test plan
- Reset, enq_count=4 with rt=1,2,3,4, deq_count=0 → next cycle count=4, free_slots=4, deq_valid=2'b11, deq_rt[0]=1, deq_rt[1]=2.
- Fill to 8 using two groups of 4 → free_slots=0. Then enq_count=3 → count stays 8, contents unchanged, and err_overflow=1 with the macro defined.
- Wrap-around:
  - Enq 4, deq 2 per cycle for 6 cycles using rt=sequence numbers mod 16.
  - Dequeued rt must be the strict sequence 0,1,2,…
  - Tail must cross entry 7→0 with no gap.
- Simultaneous events: count=7, enq_count=4, deq_count=2 → enq_acc=1, count'=6, free_slots'=2.
- Flush with count=5, enq_count=4, deq_count=2 → count'=0, deq_valid=0, free_slots=4. The next enqueue lands at entry 0.
- Assert rst asynchronously mid-cycle with count=6 → deq_valid=0 and count=0 before the next posedge. err_overflow clears.

Source files
------------

// File: rtl/instr_buffer.sv
// Circular instruction buffer between decode and issue: 4-wide program-order enqueue, DEQ_W-wide in-order dequeue, flush on taken jump.
// Optional sticky overflow flag (err_overflow) is built when IBUF_OVERFLOW_CHK_EN is defined.
module instr_buffer #(
    parameter int DEPTH = 8,
    parameter int DEQ_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [2:0]               enq_count,
    input  logic [3:0]               enq_opcode    [0:3],
    input  logic [3:0]               enq_rt        [0:3],
    input  logic [3:0]               enq_ra        [0:3],
    input  logic [3:0]               enq_rb        [0:3],
    input  logic                     enq_a_dep     [0:3],
    input  logic                     enq_b_dep     [0:3],
    input  logic [3:0]               enq_a_owner   [0:3],
    input  logic [3:0]               enq_b_owner   [0:3],
    input  logic                     enq_uses_rb   [0:3],
    input  logic                     enq_is_ld_str [0:3],
    input  logic                     enq_is_fxu    [0:3],
    input  logic                     enq_is_branch [0:3],
    output logic [2:0]               free_slots,
    output logic [DEQ_W-1:0]         deq_valid,
    output logic [3:0]               deq_opcode    [0:DEQ_W-1],
    output logic [3:0]               deq_rt        [0:DEQ_W-1],
    output logic [3:0]               deq_ra        [0:DEQ_W-1],
    output logic [3:0]               deq_rb        [0:DEQ_W-1],
    output logic                     deq_a_dep     [0:DEQ_W-1],
    output logic                     deq_b_dep     [0:DEQ_W-1],
    output logic [3:0]               deq_a_owner   [0:DEQ_W-1],
    output logic [3:0]               deq_b_owner   [0:DEQ_W-1],
    output logic                     deq_uses_rb   [0:DEQ_W-1],
    output logic                     deq_is_ld_str [0:DEQ_W-1],
    output logic                     deq_is_fxu    [0:DEQ_W-1],
    output logic                     deq_is_branch [0:DEQ_W-1],
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   count
`ifdef IBUF_OVERFLOW_CHK_EN
    ,
    output logic                     err_overflow
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   mem_r     [0:DEPTH-1];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic [CW-1:0] room_s;
    logic [2:0]    free_s;
    logic [2:0]    enq_acc_s;
    logic [CW-1:0] deq_req_s;
    logic [CW-1:0] deq_acc_s;
    logic [PW-1:0] wr_idx_s  [0:3];
    logic [29:0]   wr_data_s [0:3];
    logic [PW-1:0] rd_idx_s  [0:DEQ_W-1];
    logic [29:0]   rd_data_s [0:DEQ_W-1];

    // Capacity and accepted-lane counts, all from the pre-edge occupancy
    always_comb begin
        room_s    = CW'(DEPTH) - count_r;
        free_s    = (room_s >= CW'(4)) ? 3'd4 : room_s[2:0];
        enq_acc_s = (enq_count > free_s) ? free_s : enq_count;
        deq_req_s = CW'(deq_count);
        if (deq_req_s > count_r) begin
            deq_req_s = count_r;
        end else begin
            deq_req_s = deq_req_s;
        end
        deq_acc_s = (deq_req_s > CW'(DEQ_W)) ? CW'(DEQ_W) : deq_req_s;
    end

    // Pack each enqueue lane and compute its target entry (tail+i wraps mod DEPTH)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_idx_s[i]  = tail_r + PW'(i);
            wr_data_s[i] = {enq_opcode[i], enq_rt[i], enq_ra[i], enq_rb[i],
                            enq_a_dep[i], enq_b_dep[i], enq_a_owner[i], enq_b_owner[i],
                            enq_uses_rb[i], enq_is_ld_str[i], enq_is_fxu[i], enq_is_branch[i]};
        end
    end

    // Storage is never cleared; flush and reset only move the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!flush && (3'(i) < enq_acc_s)) begin
                mem_r[wr_idx_s[i]] <= wr_data_s[i];
            end
        end
    end

    // Pointer and occupancy update; flush overrides any same-cycle enqueue/dequeue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + PW'(deq_acc_s);
            tail_r  <= tail_r + PW'(enq_acc_s);
            count_r <= count_r + CW'(enq_acc_s) - deq_acc_s;
        end
    end

    // Combinational read of the oldest DEQ_W entries
    always_comb begin
        for (int j = 0; j < DEQ_W; j++) begin
            rd_idx_s[j]      = head_r + PW'(j);
            rd_data_s[j]     = mem_r[rd_idx_s[j]];
            deq_valid[j]     = (CW'(j) < count_r);
            deq_opcode[j]    = rd_data_s[j][29:26];
            deq_rt[j]        = rd_data_s[j][25:22];
            deq_ra[j]        = rd_data_s[j][21:18];
            deq_rb[j]        = rd_data_s[j][17:14];
            deq_a_dep[j]     = rd_data_s[j][13];
            deq_b_dep[j]     = rd_data_s[j][12];
            deq_a_owner[j]   = rd_data_s[j][11:8];
            deq_b_owner[j]   = rd_data_s[j][7:4];
            deq_uses_rb[j]   = rd_data_s[j][3];
            deq_is_ld_str[j] = rd_data_s[j][2];
            deq_is_fxu[j]    = rd_data_s[j][1];
            deq_is_branch[j] = rd_data_s[j][0];
        end
    end

    assign free_slots = free_s;
    assign count      = count_r;

`ifdef IBUF_OVERFLOW_CHK_EN
    logic err_overflow_r;

    // Sticky flag: fetch offered more lanes than there was room for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow_r <= 1'b0;
        end else if (!flush && (enq_count > free_s)) begin
            err_overflow_r <= 1'b1;
        end else begin
            err_overflow_r <= err_overflow_r;
        end
    end

    assign err_overflow = err_overflow_r;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Randomized + directed bench for instr_buffer against a queue-based reference model.
module tb_instr_buffer;
    localparam int DEPTH = 8;
    localparam int DEQ_W = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] enq_count = 3'd0;
    logic [1:0] deq_count = 2'd0;
    logic [3:0] enq_opcode [0:3], enq_rt [0:3], enq_ra [0:3], enq_rb [0:3];
    logic [3:0] enq_a_owner [0:3], enq_b_owner [0:3];
    logic       enq_a_dep [0:3], enq_b_dep [0:3], enq_uses_rb [0:3];
    logic       enq_is_ld_str [0:3], enq_is_fxu [0:3], enq_is_branch [0:3];
    logic [2:0]       free_slots;
    logic [DEQ_W-1:0] deq_valid;
    logic [3:0] deq_opcode [0:DEQ_W-1], deq_rt [0:DEQ_W-1], deq_ra [0:DEQ_W-1], deq_rb [0:DEQ_W-1];
    logic [3:0] deq_a_owner [0:DEQ_W-1], deq_b_owner [0:DEQ_W-1];
    logic       deq_a_dep [0:DEQ_W-1], deq_b_dep [0:DEQ_W-1], deq_uses_rb [0:DEQ_W-1];
    logic       deq_is_ld_str [0:DEQ_W-1], deq_is_fxu [0:DEQ_W-1], deq_is_branch [0:DEQ_W-1];
    logic [3:0] count;
`ifdef IBUF_OVERFLOW_CHK_EN
    logic       err_overflow;
`endif

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .enq_count(enq_count),
        .enq_opcode(enq_opcode), .enq_rt(enq_rt), .enq_ra(enq_ra), .enq_rb(enq_rb),
        .enq_a_dep(enq_a_dep), .enq_b_dep(enq_b_dep),
        .enq_a_owner(enq_a_owner), .enq_b_owner(enq_b_owner),
        .enq_uses_rb(enq_uses_rb), .enq_is_ld_str(enq_is_ld_str),
        .enq_is_fxu(enq_is_fxu), .enq_is_branch(enq_is_branch),
        .free_slots(free_slots), .deq_valid(deq_valid),
        .deq_opcode(deq_opcode), .deq_rt(deq_rt), .deq_ra(deq_ra), .deq_rb(deq_rb),
        .deq_a_dep(deq_a_dep), .deq_b_dep(deq_b_dep),
        .deq_a_owner(deq_a_owner), .deq_b_owner(deq_b_owner),
        .deq_uses_rb(deq_uses_rb), .deq_is_ld_str(deq_is_ld_str),
        .deq_is_fxu(deq_is_fxu), .deq_is_branch(deq_is_branch),
        .deq_count(deq_count), .count(count)
`ifdef IBUF_OVERFLOW_CHK_EN
        , .err_overflow(err_overflow)
`endif
    );

    int         checks = 0;
    int         failures = 0;
    logic [29:0] model_q [$];
    logic        ovf_m = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_free();
        return imin(4, DEPTH - model_q.size());
    endfunction

    // bench-side record of an instruction: its own field order, independent of the DUT
    function automatic logic [29:0] lane_in(input int i);
        return {enq_is_branch[i], enq_is_fxu[i], enq_is_ld_str[i], enq_uses_rb[i],
                enq_b_owner[i], enq_a_owner[i], enq_b_dep[i], enq_a_dep[i],
                enq_rb[i], enq_ra[i], enq_rt[i], enq_opcode[i]};
    endfunction

    function automatic logic [29:0] lane_out(input int j);
        return {deq_is_branch[j], deq_is_fxu[j], deq_is_ld_str[j], deq_uses_rb[j],
                deq_b_owner[j], deq_a_owner[j], deq_b_dep[j], deq_a_dep[j],
                deq_rb[j], deq_ra[j], deq_rt[j], deq_opcode[j]};
    endfunction

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++) begin
            enq_opcode[i]    = 4'($urandom);
            enq_rt[i]        = 4'($urandom);
            enq_ra[i]        = 4'($urandom);
            enq_rb[i]        = 4'($urandom);
            enq_a_owner[i]   = 4'($urandom);
            enq_b_owner[i]   = 4'($urandom);
            enq_a_dep[i]     = 1'($urandom);
            enq_b_dep[i]     = 1'($urandom);
            enq_uses_rb[i]   = 1'($urandom);
            enq_is_ld_str[i] = 1'($urandom);
            enq_is_fxu[i]    = 1'($urandom);
            enq_is_branch[i] = 1'($urandom);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [DEQ_W-1:0] vexp;
        for (int j = 0; j < DEQ_W; j++) vexp[j] = (j < model_q.size());
        check_eq({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check_eq({tag, "_free"}, 32'(free_slots), 32'(model_free()));
        check_eq({tag, "_valid"}, 32'(deq_valid), 32'(vexp));
        for (int j = 0; j < DEQ_W; j++) begin
            if (j < model_q.size()) check_eq({tag, "_lane"}, 32'(lane_out(j)), 32'(model_q[j]));
        end
`ifdef IBUF_OVERFLOW_CHK_EN
        check_eq({tag, "_ovf"}, 32'(err_overflow), 32'(ovf_m));
`endif
    endtask

    // apply the buffer's rules to the model for the inputs currently driven, then clock and compare
    task automatic step(input string tag);
        int fr, ea, da;
        if (flush) begin
            model_q.delete();
        end else begin
            fr = model_free();
            if (int'(enq_count) > fr) ovf_m = 1'b1;
            ea = imin(int'(enq_count), fr);
            da = imin(imin(int'(deq_count), model_q.size()), DEQ_W);
            for (int k = 0; k < da; k++) void'(model_q.pop_front());
            for (int i = 0; i < ea; i++) model_q.push_back(lane_in(i));
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input int ec, input int dc, input logic fl);
        rand_lanes();
        enq_count = 3'(ec);
        deq_count = 2'(dc);
        flush     = fl;
    endtask

    initial begin
        int seq, outn, acc, dacc;
        rand_lanes();
        #12;
        compare_all("reset");
        rst = 1'b0;

        // first group rt=1..4
        drive(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) enq_rt[i] = 4'(i + 1);
        step("first");
        check_eq("first_rt0", 32'(deq_rt[0]), 32'd1);
        check_eq("first_rt1", 32'(deq_rt[1]), 32'd2);
        check_eq("first_valid", 32'(deq_valid), 32'd3);

        // fill, then over-offer while full
        drive(4, 0, 1'b0); step("fill");
        check_eq("full_free", 32'(free_slots), 32'd0);
        drive(3, 0, 1'b0); step("overfull");
        check_eq("overfull_count", 32'(count), 32'd8);

        // offset head/tail to 3 so a 4-lane group straddles entry 7->0
        drive(0, 0, 1'b1); step("flush0");
        drive(3, 0, 1'b0); step("off_a");
        drive(0, 2, 1'b0); step("off_b");
        drive(0, 2, 1'b0); step("off_c");
        seq = 0;
        outn = 0;
        for (int c = 0; c < 6; c++) begin
            drive(4, 2, 1'b0);
            for (int i = 0; i < 4; i++) enq_rt[i] = 4'(seq + i);
            acc  = model_free();
            dacc = imin(2, model_q.size());
            step("wrap");
            seq  += acc;
            outn += dacc;
            for (int j = 0; j < imin(DEQ_W, model_q.size()); j++)
                check_eq("wrap_seq", 32'(deq_rt[j]), 32'((outn + j) % 16));
        end

        // simultaneous enqueue/dequeue at count=7
        drive(0, 0, 1'b1); step("flush1");
        drive(4, 0, 1'b0); step("sim_a");
        drive(3, 0, 1'b0); step("sim_b");
        drive(4, 2, 1'b0); step("sim_c");
        check_eq("sim_count", 32'(count), 32'd6);
        check_eq("sim_free", 32'(free_slots), 32'd2);

        // flush beats same-cycle enqueue/dequeue at count=5
        drive(0, 0, 1'b1); step("flush2");
        drive(4, 0, 1'b0); step("fl_a");
        drive(1, 0, 1'b0); step("fl_b");
        drive(4, 2, 1'b1); step("fl_c");
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_valid", 32'(deq_valid), 32'd0);
        drive(1, 0, 1'b0);
        enq_rt[0] = 4'd9;
        step("post_flush");
        check_eq("post_flush_rt", 32'(deq_rt[0]), 32'd9);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(4, 0), $urandom_range(3, 0), ($urandom_range(19, 0) == 0));
            step("rand");
        end

        // asynchronous reset mid-cycle at count=6
        drive(0, 0, 1'b1); step("flush3");
        drive(4, 0, 1'b0); step("ar_a");
        drive(4, 2, 1'b0); step("ar_b");
        drive(0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        ovf_m = 1'b0;
        compare_all("async_rst");
        #1;
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive($urandom_range(4, 0), $urandom_range(3, 0), ($urandom_range(29, 0) == 0));
            step("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
